dram_loader: RTL and testbench
==============================

Name: dram_loader

Overview:
- Diagnostic-side writer for the IR dispatch RAM: 512 words × 15 bits, fields A, B, PAR, J[1:4], J[7:10].
- The front end stages an address and field values through EBUS diagnostic load functions. The block packs the word, generates PAR, writes the RAM port, then reads the word back to verify it.
- Sits beside the IR board and owns the DRAM write port.
- While `dram_own` is high, the IR board's address mux selects `dram_addr`.

Parameters:
- `DRAM_WIDTH`, 15, packed word width.
- `DRAM_SIZE`, 512, words in the dispatch RAM.
- `DRAM_ADDR_BITS`, 9, address width (`$clog2(DRAM_SIZE)`).
- `VERIFY`, 1, 1 = read back and compare after every write; 0 = write only.

Ports:
- `clk`, in, 1: the only clock; all state is updated on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `diag_strobe`, in, 1: one-cycle pulse, diagnostic load function valid.
- `diag_func`, in, 3: DIAG[4:6] function select.
- `diag_data`, in, 6: EBUS data[0:5].
- `dram_addr`, out, 9: RAM address; bit 0 is the MSB.
- `dram_din`, out, 15: packed write word.
- `dram_we`, out, 1: RAM write enable.
- `dram_dout`, in, 15: RAM read data; registered, 1-cycle latency.
- `dram_own`, out, 1: loader owns the RAM address port.
- `busy`, out, 1: write/verify sequence in progress.
- `done`, out, 1: one-cycle pulse when a sequence completes.
- `status`, out, 6: {`busy`, `verify_err`, `overrun`, `addr_wrap`, `dram_own`, 1'b0}, for EBUS diagnostic read.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - `dram_we`, `busy`, `done`, `dram_own` = 0.
  - Staged A, B, J1, J7 = 0; address = 0; all sticky flags = 0.
  - `dram_din` = 0o00400 (PAR of the all-zero field set).
- Packing: `dram_din` = {A[0:2], B[0:2], PAR, J1[0:3], J7[0:3]}.
  - PAR is chosen so the XOR of all 15 bits is 1 (odd parity).
  - `dram_din` is combinational from the staged registers.
- Functions, sampled when `diag_strobe` is high in IDLE:
  - 0: addr[0:2] ← `diag_data`[3:5].
  - 1: addr[3:8] ← `diag_data`[0:5].
  - 2: {A, B} ← `diag_data`[0:5].
  - 3: J1 ← `diag_data`[2:5].
  - 4: J7 ← `diag_data`[2:5].
  - 5: commit.
  - 6: commit, then auto-increment the address.
  - 7: abort/clear.
- States: IDLE → WRITE → READ → CHECK → IDLE.
  - Cycle 0: commit strobe sampled; the snapshot (address, word) is latched.
  - WRITE (cycle 1): `dram_we` = 1; `dram_own` = 1; `busy` = 1.
  - READ (cycle 2): `dram_we` = 0; same address held.
  - CHECK (cycle 3): compare `dram_dout` with the snapshot; a mismatch sets sticky `verify_err`. `done` pulses. For func 6, address ← address + 1.
  - Back in IDLE at cycle 4; `busy` and `dram_own` drop.
- With `VERIFY` = 0: WRITE → IDLE; `done` pulses in the WRITE cycle; the func 6 increment happens in the same cycle.
- Address wrap: incrementing from 511 gives 0 and sets sticky `addr_wrap`.
- Strobe while `busy`:
  - Func 0–6 are ignored and set sticky `overrun`.
  - Func 7 is honoured immediately.
- Abort (func 7), in any state:
  - Next state = IDLE; `dram_we` deasserts on the following edge.
  - Staged fields, address and sticky flags are cleared.
  - `done` is not pulsed.
- Staged field writes do not alter an in-flight snapshot.
- No other state is cleared by a commit: fields persist for the next word.
- Simultaneous increment and abort in CHECK: the abort wins and the address becomes 0.

Decomposition:
- Shared package `dram_pkg`:
  - Constants: `DRAM_WIDTH`, `DRAM_SIZE`, `DRAM_ADDR_BITS`.
  - Field-position localparams: A = 0:2, B = 3:5, PAR = 6, J1 = 7:10, J7 = 11:14.
  - Packed struct typedef `dram_word_t`.
  - Function-code enum `dram_ld_func_e`.
- These are reused by the IR board's unpacking and by `tools/write-dram-mem.js` checks.
- Sub-module `dram_word_pack`: combinational packing plus PAR generation. It is shared, and the IR board's odd-parity check can reuse it.

Test Plan:
1. Pack and write:
   - Stimulus: func 0 data 0o02, func 1 data 0o54 (address 0o254); func 2 data 0o15 (A=1, B=5); func 3 data 0o05; func 4 data 0o03; func 5.
   - Required: `dram_we` high for exactly 1 cycle with `dram_addr` = 0o254 and `dram_din` = 0o15123 (PAR = 0). `done` pulses at cycle 3; `verify_err` = 0.
2. Parity:
   - Stimulus: after reset, commit all-zero fields.
   - Required: `dram_din` = 0o00400 (PAR = 1).
3. Auto-increment and wrap:
   - Stimulus: address 0o777, func 6 twice.
   - Required: writes go to 0o777 then 0; `addr_wrap` = 1.
4. Verify failure:
   - Stimulus: RAM model returns the written word with bit 14 flipped.
   - Required: `verify_err` = 1 and `status` = 6'b010000 once idle.
5. Overrun and abort:
   - Stimulus: func 2 strobe during WRITE → staged A/B unchanged and `overrun` = 1. Func 7 during READ.
   - Required: IDLE next cycle, no `done`, all flags 0, address 0.
6. Reset mid-operation:
   - Stimulus: assert `reset` in the WRITE cycle, asynchronously to `clk`.
   - Required: `dram_we` and `busy` drop without waiting for a clock edge; all outputs take their reset values.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the IR dispatch RAM (512 x 15).
// Word layout, MSB first (bit 0 is the MSB):
//   A[0:2] | B[0:2] | PAR | J1[0:3] | J7[0:3]
// The IR board's unpacking logic and the memory-image tooling use the same
// constants, so field positions live here and nowhere else.
package dram_pkg;

  localparam int DRAM_WIDTH     = 15;
  localparam int DRAM_SIZE      = 512;
  localparam int DRAM_ADDR_BITS = $clog2(DRAM_SIZE);

  // Field positions in MSB-first numbering.
  localparam int A_FIRST  = 0;
  localparam int A_LAST   = 2;
  localparam int B_FIRST  = 3;
  localparam int B_LAST   = 5;
  localparam int PAR_BIT  = 6;
  localparam int J1_FIRST = 7;
  localparam int J1_LAST  = 10;
  localparam int J7_FIRST = 11;
  localparam int J7_LAST  = 14;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       par;
    logic [3:0] j1;
    logic [3:0] j7;
  } dram_word_t;

  // DIAG[4:6] load function codes.
  typedef enum logic [2:0] {
    LD_ADDR_HI    = 3'd0,
    LD_ADDR_LO    = 3'd1,
    LD_AB         = 3'd2,
    LD_J1         = 3'd3,
    LD_J7         = 3'd4,
    LD_COMMIT     = 3'd5,
    LD_COMMIT_INC = 3'd6,
    LD_ABORT      = 3'd7
  } dram_ld_func_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK
  } dram_ld_state_e;

  // Map an MSB-first field position onto a descending vector index.
  function automatic int bit_idx(input int pos);
    return DRAM_WIDTH - 1 - pos;
  endfunction

endpackage

// File: rtl/dram_word_pack.sv
// Combinational packer for one dispatch RAM word with odd-parity generation.
// Ports:
//   a, b   : 3-bit A and B fields
//   j1, j7 : 4-bit J[1:4] and J[7:10] fields
//   word   : packed 15-bit word; PAR makes the XOR of all 15 bits equal 1
module dram_word_pack
  import dram_pkg::*;
(
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [3:0] j1,
  input  logic [3:0] j7,
  output dram_word_t word
);

  logic [DRAM_WIDTH-1:0] w;

  always_comb begin
    w = '0;
    w[bit_idx(A_FIRST)  -: (A_LAST  - A_FIRST  + 1)] = a;
    w[bit_idx(B_FIRST)  -: (B_LAST  - B_FIRST  + 1)] = b;
    w[bit_idx(J1_FIRST) -: (J1_LAST - J1_FIRST + 1)] = j1;
    w[bit_idx(J7_FIRST) -: (J7_LAST - J7_FIRST + 1)] = j7;
    // PAR is set when the data fields hold an even number of ones.
    w[bit_idx(PAR_BIT)] = ~^{a, b, j1, j7};
  end

  assign word = w;

endmodule

// File: rtl/dram_loader.sv
// Diagnostic-side writer for the IR dispatch RAM. EBUS diagnostic load
// functions stage an address and field values; a commit writes the packed
// word, then (VERIFY=1) reads it back and compares.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   diag_strobe          : one-cycle load function valid
//   diag_func, diag_data : DIAG[4:6] function select, EBUS data[0:5]
//   dram_addr, dram_din  : RAM address and write word (MSB is bit 0)
//   dram_we, dram_dout   : RAM write enable, registered read data
//   dram_own             : loader drives the IR board's RAM address mux
//   busy, done           : sequence in progress, one-cycle completion pulse
//   status               : {busy, verify_err, overrun, addr_wrap, dram_own, 0}
module dram_loader
  import dram_pkg::*;
#(
  parameter int VERIFY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      diag_strobe,
  input  logic [2:0]                diag_func,
  input  logic [5:0]                diag_data,
  output logic [DRAM_ADDR_BITS-1:0] dram_addr,
  output logic [DRAM_WIDTH-1:0]     dram_din,
  output logic                      dram_we,
  input  logic [DRAM_WIDTH-1:0]     dram_dout,
  output logic                      dram_own,
  output logic                      busy,
  output logic                      done,
  output logic [5:0]                status
);

  dram_ld_state_e state, state_nx;
  dram_ld_func_e  func;

  logic [DRAM_ADDR_BITS-1:0] addr;
  logic [2:0]                a, b;
  logic [3:0]                j1, j7;
  logic                      verify_err, overrun, addr_wrap;
  dram_word_t                packed_word, snap_word;
  logic                      snap_inc;
  logic                      abort, commit, finish, inc_now;

  assign func   = dram_ld_func_e'(diag_func);
  assign abort  = diag_strobe && (func == LD_ABORT);
  assign commit = diag_strobe && (state == ST_IDLE) &&
                  ((func == LD_COMMIT) || (func == LD_COMMIT_INC));

  dram_word_pack u_pack (
    .a    (a),
    .b    (b),
    .j1   (j1),
    .j7   (j7),
    .word (packed_word)
  );

  // Staged fields cannot change while busy (those strobes are rejected),
  // so the live packed word equals the snapshot for the whole sequence.
  assign dram_din  = packed_word;
  assign dram_addr = addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    dram_we  = 1'b0;
    dram_own = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        dram_we  = 1'b1;
        dram_own = 1'b1;
        if (VERIFY != 0) begin
          state_nx = ST_READ;
        end else begin
          state_nx = ST_IDLE;
          finish   = 1'b1;
        end
      end
      ST_READ: begin
        dram_own = 1'b1;
        state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        dram_own = 1'b1;
        finish   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Abort is honoured from any state.
    if (abort) state_nx = ST_IDLE;
  end

  assign busy    = dram_own;
  assign done    = finish && !abort;
  assign inc_now = done && snap_inc;
  assign status  = {busy, verify_err, overrun, addr_wrap, dram_own, 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      a          <= '0;
      b          <= '0;
      j1         <= '0;
      j7         <= '0;
      verify_err <= 1'b0;
      overrun    <= 1'b0;
      addr_wrap  <= 1'b0;
      snap_word  <= '0;
      snap_inc   <= 1'b0;
    end else if (abort) begin
      // Abort beats a same-cycle increment, leaving the address at 0.
      addr       <= '0;
      a          <= '0;
      b          <= '0;
      j1         <= '0;
      j7         <= '0;
      verify_err <= 1'b0;
      overrun    <= 1'b0;
      addr_wrap  <= 1'b0;
      snap_inc   <= 1'b0;
    end else begin
      if (diag_strobe && (state == ST_IDLE)) begin
        case (func)
          LD_ADDR_HI:    addr[DRAM_ADDR_BITS-1 -: 3] <= diag_data[2:0];
          LD_ADDR_LO:    addr[5:0] <= diag_data;
          LD_AB:         {a, b} <= diag_data;
          LD_J1:         j1 <= diag_data[3:0];
          LD_J7:         j7 <= diag_data[3:0];
          LD_COMMIT,
          LD_COMMIT_INC: begin
            snap_word <= packed_word;
            snap_inc  <= (func == LD_COMMIT_INC);
          end
          default: ;
        endcase
      end
      if (diag_strobe && (state != ST_IDLE)) overrun <= 1'b1;
      if ((state == ST_CHECK) && (dram_dout != snap_word)) verify_err <= 1'b1;
      if (inc_now) begin
        addr <= addr + 1'b1;
        if (addr == DRAM_ADDR_BITS'(DRAM_SIZE - 1)) addr_wrap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_loader.sv
// Bench for dram_loader: directed sequences with literal expectations plus
// randomized load functions, all checked every cycle against a
// transaction-level model of the loader.
module tb_dram_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        diag_strobe = 1'b0;
  logic [2:0]  diag_func = '0;
  logic [5:0]  diag_data = '0;
  logic [8:0]  dram_addr;
  logic [14:0] dram_din;
  logic        dram_we;
  logic [14:0] dram_dout;
  logic        dram_own, busy, done;
  logic [5:0]  status;
  logic        flip = 1'b0;

  int checks = 0;
  int failures = 0;

  dram_loader dut (
    .clk         (clk),
    .reset       (reset),
    .diag_strobe (diag_strobe),
    .diag_func   (diag_func),
    .diag_data   (diag_data),
    .dram_addr   (dram_addr),
    .dram_din    (dram_din),
    .dram_we     (dram_we),
    .dram_dout   (dram_dout),
    .dram_own    (dram_own),
    .busy        (busy),
    .done        (done),
    .status      (status)
  );

  always #5 clk = ~clk;

  // RAM with registered read; flip corrupts bit 14 of the read data.
  logic [14:0] mem [512];
  logic [14:0] ram_q;
  always @(posedge clk) begin
    if (dram_we) mem[dram_addr] <= dram_din;
    ram_q <= mem[dram_addr];
  end
  assign dram_dout = ram_q ^ (flip ? 15'h4000 : 15'h0000);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_a, m_b, m_j1, m_j7, m_addr;
  int m_phase;            // 0 idle, 1..3 = cycle within the sequence
  bit m_inc, m_verr, m_ovr, m_wrap;

  function automatic int mpack(input int a, input int b, input int j1, input int j7);
    int ones;
    int par;
    ones = $countones(a) + $countones(b) + $countones(j1) + $countones(j7);
    par  = (ones % 2 == 0) ? 1 : 0;
    return a * 4096 + b * 512 + par * 256 + j1 * 16 + j7;
  endfunction

  task automatic model_clear();
    m_a = 0; m_b = 0; m_j1 = 0; m_j7 = 0; m_addr = 0;
    m_phase = 0; m_inc = 0; m_verr = 0; m_ovr = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    int f;
    f = int'(diag_func);
    if (diag_strobe && f == 7) begin
      model_clear();
    end else if (m_phase != 0) begin
      if (diag_strobe) m_ovr = 1;
      if (m_phase == 3) begin
        if (flip) m_verr = 1;
        if (m_inc) begin
          if (m_addr == 511) m_wrap = 1;
          m_addr = (m_addr + 1) % 512;
        end
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end else if (diag_strobe) begin
      case (f)
        0: m_addr = (int'(diag_data) % 8) * 64 + (m_addr % 64);
        1: m_addr = (m_addr / 64) * 64 + int'(diag_data);
        2: begin m_a = int'(diag_data) / 8; m_b = int'(diag_data) % 8; end
        3: m_j1 = int'(diag_data) % 16;
        4: m_j7 = int'(diag_data) % 16;
        default: begin m_phase = 1; m_inc = (f == 6); end
      endcase
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    bit exp_busy, exp_done;
    exp_busy = (m_phase != 0);
    exp_done = (m_phase == 3) && !(diag_strobe && diag_func == 3'd7);
    chk("we", 32'(dram_we), 32'(m_phase == 1));
    chk("own", 32'(dram_own), 32'(exp_busy));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("din", 32'(dram_din), 32'(mpack(m_a, m_b, m_j1, m_j7)));
    chk("status", 32'(status),
        32'({exp_busy, m_verr, m_ovr, m_wrap, exp_busy, 1'b0}));
    if (exp_busy) chk("addr", 32'(dram_addr), 32'(m_addr));
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at the following posedge+1.
  task automatic pulse(input int f, input int d);
    diag_strobe = 1'b1;
    diag_func   = 3'(f);
    diag_data   = 6'(d);
    @(posedge clk); #1;
    diag_strobe = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    cycles(2);
    chk("lit_reset_din", 32'(dram_din), 32'o00400);
    chk("lit_reset_status", 32'(status), 32'd0);
    chk("lit_reset_we", 32'(dram_we), 32'd0);
    reset = 1'b0;
    cycles(1);

    // Pack and write.
    pulse(0, 'o02); pulse(1, 'o54); pulse(2, 'o15);
    pulse(3, 'o05); pulse(4, 'o03); pulse(5, 0);
    chk("lit_t1_we", 32'(dram_we), 32'd1);
    chk("lit_t1_addr", 32'(dram_addr), 32'o254);
    chk("lit_t1_din", 32'(dram_din), 32'o15123);
    cycles(1);
    chk("lit_t1_we_low", 32'(dram_we), 32'd0);
    cycles(1);
    chk("lit_t1_done", 32'(done), 32'd1);
    chk("lit_t1_verr", 32'(status[4]), 32'd0);
    cycles(1);
    chk("lit_t1_idle", 32'(busy), 32'd0);

    // Parity of the all-zero word.
    pulse(7, 0);
    pulse(5, 0);
    chk("lit_t2_din", 32'(dram_din), 32'o00400);
    cycles(3);

    // Auto-increment and wrap.
    pulse(0, 'o07); pulse(1, 'o77); pulse(6, 0);
    chk("lit_t3_addr0", 32'(dram_addr), 32'o777);
    cycles(3);
    pulse(6, 0);
    chk("lit_t3_addr1", 32'(dram_addr), 32'd0);
    cycles(3);
    chk("lit_t3_wrap", 32'(status[2]), 32'd1);

    // Verify failure.
    pulse(7, 0);
    flip = 1'b1;
    pulse(5, 0);
    cycles(3);
    flip = 1'b0;
    chk("lit_t4_status", 32'(status), 32'b010000);

    // Overrun then abort.
    pulse(7, 0);
    pulse(2, 'o15);
    pulse(5, 0);
    pulse(2, 'o77);
    chk("lit_t5_ovr", 32'(status[3]), 32'd1);
    chk("lit_t5_din", 32'(dram_din), 32'(mpack(1, 5, 0, 0)));
    pulse(7, 0);
    chk("lit_t5_idle", 32'(busy), 32'd0);
    chk("lit_t5_status", 32'(status), 32'd0);
    chk("lit_t5_din0", 32'(dram_din), 32'o00400);
    pulse(5, 0);
    chk("lit_t5_addr", 32'(dram_addr), 32'd0);
    cycles(3);

    // Asynchronous reset in the WRITE cycle.
    pulse(2, 'o33);
    pulse(5, 0);
    #3 reset = 1'b1;
    #1;
    chk("lit_t6_we", 32'(dram_we), 32'd0);
    chk("lit_t6_busy", 32'(busy), 32'd0);
    chk("lit_t6_done", 32'(done), 32'd0);
    chk("lit_t6_din", 32'(dram_din), 32'o00400);
    chk("lit_t6_status", 32'(status), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycles(1);

    // Randomized load functions.
    for (int i = 0; i < 1500; i++) begin
      int r;
      flip = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) < 4) begin
        r = $urandom_range(0, 15);
        diag_strobe = 1'b1;
        diag_func   = (r >= 14) ? 3'd7 : 3'(r % 7);
        diag_data   = 6'($urandom_range(0, 63));
      end else begin
        diag_strobe = 1'b0;
      end
      @(posedge clk); #1;
    end
    diag_strobe = 1'b0;
    flip = 1'b0;
    cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
